// File: rtl/conv_window_ctrl.sv
// Address sequencer for the BNN convolution datapath: walks every KxK window of an
// IMG_H x IMG_W feature map (tap reads, then one output write per window) with stall support.
module conv_window_ctrl #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 3,
   parameter int STRIDE = 1,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              en,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic              first_tap,
   output logic [ADDR_W-1:0] graph_mem_rowaddr,
   output logic [ADDR_W-1:0] graph_mem_coladdr,
   output logic [ADDR_W-1:0] out_mem_rowaddr,
   output logic [ADDR_W-1:0] out_mem_coladdr,
   output logic              WR
);

   localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
   localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
   localparam int PW    = ADDR_W + $clog2(STRIDE) + 1;

   localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ZERO   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(K - 1);
   localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(OUT_W - 1);
   localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(OUT_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] kr_q, kr_d, kc_q, kc_d;
   logic [ADDR_W-1:0] orow_q, orow_d, ocol_q, ocol_d;
   logic [PW-1:0]     g_row_full, g_col_full;
   logic              active;

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         kr_q    <= ZERO;
         kc_q    <= ZERO;
         orow_q  <= ZERO;
         ocol_q  <= ZERO;
      end else begin
         state_q <= state_d;
         kr_q    <= kr_d;
         kc_q    <= kc_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
      end
   end

   // Next-state and counter stepping; en=0 holds everything except the DONE pulse
   always_comb begin
      state_d = state_q;
      kr_d    = kr_q;
      kc_d    = kc_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               kr_d    = ZERO;
               kc_d    = ZERO;
               orow_d  = ZERO;
               ocol_d  = ZERO;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (en) begin
               if (kc_q == K_LAST) begin
                  kc_d = ZERO;
                  if (kr_q == K_LAST) begin
                     kr_d    = ZERO;
                     state_d = WRITE;
                  end else begin
                     kr_d = kr_q + ONE;
                  end
               end else begin
                  kc_d = kc_q + ONE;
               end
            end else begin
               state_d = READ;
            end
         end
         WRITE: begin
            if (en) begin
               kr_d = ZERO;
               kc_d = ZERO;
               if (orow_q == R_LAST && ocol_q == C_LAST) begin
                  state_d = DONE;
                  orow_d  = ZERO;
                  ocol_d  = ZERO;
               end else if (ocol_q == C_LAST) begin
                  state_d = READ;
                  ocol_d  = ZERO;
                  orow_d  = orow_q + ONE;
               end else begin
                  state_d = READ;
                  ocol_d  = ocol_q + ONE;
               end
            end else begin
               state_d = WRITE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from registers and en only; addresses forced to 0 outside READ/WRITE
   always_comb begin
      active     = (state_q == READ) || (state_q == WRITE);
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      rd_en      = (state_q == READ) && en;
      first_tap  = rd_en && (kr_q == ZERO) && (kc_q == ZERO);
      WR         = (state_q == WRITE) && en;
      g_row_full = PW'(orow_q) * PW'(STRIDE) + PW'(kr_q);
      g_col_full = PW'(ocol_q) * PW'(STRIDE) + PW'(kc_q);
      if (active) begin
         graph_mem_rowaddr = g_row_full[ADDR_W-1:0];
         graph_mem_coladdr = g_col_full[ADDR_W-1:0];
         out_mem_rowaddr   = orow_q;
         out_mem_coladdr   = ocol_q;
      end else begin
         graph_mem_rowaddr = ZERO;
         graph_mem_coladdr = ZERO;
         out_mem_rowaddr   = ZERO;
         out_mem_coladdr   = ZERO;
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: 4x4/K2/S2 table, 5x5/K2/S2 and default 28x28 frames.
module tb_conv_window_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

   logic       busy_a, done_a, rd_a, ft_a, wr_a;
   logic [1:0] gr_a, gc_a, or_a, oc_a;
   logic       busy_b, done_b, rd_b, ft_b, wr_b;
   logic [2:0] gr_b, gc_b, or_b, oc_b;
   logic       busy_c, done_c, rd_c, ft_c, wr_c;
   logic [4:0] gr_c, gc_c, or_c, oc_c;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(2), .STRIDE(2), .ADDR_W(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .en(en), .busy(busy_a), .done(done_a),
      .rd_en(rd_a), .first_tap(ft_a), .graph_mem_rowaddr(gr_a), .graph_mem_coladdr(gc_a),
      .out_mem_rowaddr(or_a), .out_mem_coladdr(oc_a), .WR(wr_a));

   conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .K(2), .STRIDE(2), .ADDR_W(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .en(en), .busy(busy_b), .done(done_b),
      .rd_en(rd_b), .first_tap(ft_b), .graph_mem_rowaddr(gr_b), .graph_mem_coladdr(gc_b),
      .out_mem_rowaddr(or_b), .out_mem_coladdr(oc_b), .WR(wr_b));

   conv_window_ctrl dut_c (
      .clk(clk), .rst(rst), .start(start_c), .en(en), .busy(busy_c), .done(done_c),
      .rd_en(rd_c), .first_tap(ft_c), .graph_mem_rowaddr(gr_c), .graph_mem_coladdr(gc_c),
      .out_mem_rowaddr(or_c), .out_mem_coladdr(oc_c), .WR(wr_c));

   typedef struct {
      bit en; bit rd; bit ft; int gr; int gc; bit wr; int orr; int oc; bit dn; bit bz;
   } vec_t;

   vec_t tab[22];

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One cycle of dut_a: drive at negedge, compare 1 time unit later
   task automatic apply(input vec_t v, input bit st, input string tag);
      @(negedge clk);
      start_a = st;
      en      = v.en;
      #1;
      check({tag, " rd_en"}, int'(rd_a), int'(v.rd));
      check({tag, " first_tap"}, int'(ft_a), int'(v.ft));
      check({tag, " WR"}, int'(wr_a), int'(v.wr));
      check({tag, " done"}, int'(done_a), int'(v.dn));
      check({tag, " busy"}, int'(busy_a), int'(v.bz));
      if (v.rd) begin
         check({tag, " g_row"}, int'(gr_a), v.gr);
         check({tag, " g_col"}, int'(gc_a), v.gc);
      end
      if (v.wr) begin
         check({tag, " o_row"}, int'(or_a), v.orr);
         check({tag, " o_col"}, int'(oc_a), v.oc);
      end
      if (v.dn || !v.bz) begin
         check({tag, " zero_addr"}, int'({gr_a, gc_a, or_a, oc_a}), 0);
      end
   endtask

   initial begin
      int stall_n[22];
      int cyc, done_cyc, n_rd, n_wr, n_ft, max_r, max_c, lr_r, lr_c, lw_r, lw_c;
      //           en rd ft gr gc wr or oc dn bz
      tab[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
      tab[1]  = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1};
      tab[2]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 1};
      tab[3]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 1};
      tab[4]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1};
      tab[5]  = '{1, 1, 1, 0, 2, 0, 0, 0, 0, 1};
      tab[6]  = '{1, 1, 0, 0, 3, 0, 0, 0, 0, 1};
      tab[7]  = '{1, 1, 0, 1, 2, 0, 0, 0, 0, 1};
      tab[8]  = '{1, 1, 0, 1, 3, 0, 0, 0, 0, 1};
      tab[9]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 1};
      tab[10] = '{1, 1, 1, 2, 0, 0, 0, 0, 0, 1};
      tab[11] = '{1, 1, 0, 2, 1, 0, 0, 0, 0, 1};
      tab[12] = '{1, 1, 0, 3, 0, 0, 0, 0, 0, 1};
      tab[13] = '{1, 1, 0, 3, 1, 0, 0, 0, 0, 1};
      tab[14] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 1};
      tab[15] = '{1, 1, 1, 2, 2, 0, 0, 0, 0, 1};
      tab[16] = '{1, 1, 0, 2, 3, 0, 0, 0, 0, 1};
      tab[17] = '{1, 1, 0, 3, 2, 0, 0, 0, 0, 1};
      tab[18] = '{1, 1, 0, 3, 3, 0, 0, 0, 0, 1};
      tab[19] = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 1};
      tab[20] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      tab[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      foreach (stall_n[i]) stall_n[i] = 0;
      stall_n[2] = 3;
      stall_n[9] = 2;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset busy", int'(busy_a), 0);
      check("reset rd_en", int'(rd_a), 0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("idle busy", int'(busy_a), 0);

      // Case 2: full frame, en=1
      @(negedge clk);
      start_a = 1'b1;
      for (int i = 0; i < 22; i++) apply(tab[i], 1'b0, $sformatf("c2[%0d]", i));

      // Case 4: same frame with stalls mid-window and in WRITE
      @(negedge clk);
      start_a = 1'b1;
      cyc = 0;
      done_cyc = -1;
      for (int i = 0; i < 22; i++) begin
         for (int s = 0; s < stall_n[i]; s++) begin
            vec_t sv;
            sv = tab[i];
            sv.en = 1'b0; sv.rd = 1'b0; sv.ft = 1'b0; sv.wr = 1'b0;
            cyc++;
            apply(sv, 1'b0, $sformatf("c4stall[%0d]", i));
            if (tab[i].rd) begin
               check("c4 hold g_row", int'(gr_a), tab[i].gr);
               check("c4 hold g_col", int'(gc_a), tab[i].gc);
            end
            if (tab[i].wr) begin
               check("c4 hold o_row", int'(or_a), tab[i].orr);
               check("c4 hold o_col", int'(oc_a), tab[i].oc);
            end
         end
         cyc++;
         apply(tab[i], 1'b0, $sformatf("c4[%0d]", i));
         if (done_a && done_cyc < 0) done_cyc = cyc;
      end
      check("c4 done cycle", done_cyc, 26);

      // Case 5: start ignored while busy, then async reset mid-frame
      @(negedge clk);
      start_a = 1'b1;
      for (int i = 0; i < 8; i++) apply(tab[i], (i == 5 || i == 6), $sformatf("c5[%0d]", i));
      @(negedge clk);
      start_a = 1'b0;
      rst = 1'b1;
      #1;
      check("c5 rst busy", int'(busy_a), 0);
      check("c5 rst rd_en", int'(rd_a), 0);
      check("c5 rst first_tap", int'(ft_a), 0);
      check("c5 rst WR", int'(wr_a), 0);
      check("c5 rst done", int'(done_a), 0);
      check("c5 rst addr", int'({gr_a, gc_a, or_a, oc_a}), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("c5 idle after rst", int'(busy_a), 0);
      @(negedge clk);
      start_a = 1'b1;
      for (int i = 0; i < 6; i++) apply(tab[i], 1'b0, $sformatf("c5r[%0d]", i));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Case 6: start held high across DONE
      @(negedge clk);
      start_a = 1'b1;
      en = 1'b1;
      n_ft = 0;
      done_cyc = -1;
      for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
         @(negedge clk);
         #1;
         if (ft_a) n_ft++;
         if (done_a) done_cyc = c;
      end
      check("c6 done cycle", done_cyc, 21);
      check("c6 first_tap count 1", n_ft, 4);
      @(negedge clk);
      #1;
      check("c6 idle busy", int'(busy_a), 0);
      @(negedge clk);
      #1;
      check("c6 restart rd_en", int'(rd_a), 1);
      check("c6 restart first_tap", int'(ft_a), 1);
      check("c6 restart g_row", int'(gr_a), 0);
      check("c6 restart g_col", int'(gc_a), 0);
      start_a = 1'b0;
      n_ft = 1;
      done_cyc = -1;
      for (int c = 2; c <= 60 && done_cyc < 0; c++) begin
         @(negedge clk);
         #1;
         if (ft_a) n_ft++;
         if (done_a) done_cyc = c;
      end
      check("c6 second done cycle", done_cyc, 21);
      check("c6 first_tap count 2", n_ft, 4);

      // Case 3: 5x5, K=2, STRIDE=2 -> row/col 4 never read
      @(negedge clk);
      start_b = 1'b1;
      n_rd = 0; n_wr = 0; max_r = 0; max_c = 0; lw_r = -1; lw_c = -1; done_cyc = -1;
      for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
         @(negedge clk);
         start_b = 1'b0;
         #1;
         if (rd_b) begin
            n_rd++;
            if (int'(gr_b) > max_r) max_r = int'(gr_b);
            if (int'(gc_b) > max_c) max_c = int'(gc_b);
         end
         if (wr_b) begin
            n_wr++; lw_r = int'(or_b); lw_c = int'(oc_b);
         end
         if (done_b) done_cyc = c;
      end
      check("c3 done cycle", done_cyc, 21);
      check("c3 reads", n_rd, 16);
      check("c3 writes", n_wr, 4);
      check("c3 max row read", max_r, 3);
      check("c3 max col read", max_c, 3);
      check("c3 last write row", lw_r, 1);
      check("c3 last write col", lw_c, 1);

      // Case 1: default 28x28, K=3, STRIDE=1
      @(negedge clk);
      start_c = 1'b1;
      n_rd = 0; n_wr = 0; max_r = 0; max_c = 0; done_cyc = -1;
      lr_r = -1; lr_c = -1; lw_r = -1; lw_c = -1;
      for (int c = 1; c <= 8000 && done_cyc < 0; c++) begin
         @(negedge clk);
         start_c = 1'b0;
         #1;
         if (rd_c) begin
            n_rd++; lr_r = int'(gr_c); lr_c = int'(gc_c);
            if (lr_r > max_r) max_r = lr_r;
            if (lr_c > max_c) max_c = lr_c;
         end
         if (wr_c) begin
            n_wr++; lw_r = int'(or_c); lw_c = int'(oc_c);
         end
         if (done_c) done_cyc = c;
      end
      check("c1 done cycle", done_cyc, 6761);
      check("c1 reads", n_rd, 6084);
      check("c1 writes", n_wr, 676);
      check("c1 last read row", lr_r, 27);
      check("c1 last read col", lr_c, 27);
      check("c1 last write row", lw_r, 25);
      check("c1 last write col", lw_c, 25);
      check("c1 max row read", max_r, 27);
      check("c1 max col read", max_c, 27);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
